// File: rtl/sro_rx_pkg.sv
// Shared definitions for the ETROC1 simple-readout receiver: word tags, field
// positions, FSM encoding, hit record and small bit-counting helpers.
package sro_rx_pkg;

  localparam int          WORD_W    = 30;
  localparam logic [29:0] IDLE_WORD = 30'h2AAA_AAAA;
  localparam logic [5:0]  HDR_TAG   = 6'h3C;
  localparam logic [5:0]  TRL_TAG   = 6'h33;

  localparam int TAG_MSB  = 29;
  localparam int TAG_LSB  = 24;
  localparam int BCID_MSB = 23;
  localparam int BCID_LSB = 12;
  localparam int ECHO_MSB = 23;
  localparam int ECHO_LSB = 8;
  localparam int CNT_MSB  = 7;
  localparam int CNT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TRAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        index;
    logic [WORD_W-1:0] data;
  } hit_t;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sro_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is presented as soon
// as it is written. Push while full is accepted only when a pop happens too.
module sro_rx_fifo #(
  parameter int W  = 34,
  parameter int AW = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr_en, rd_en;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Zero the output while empty so the head never shows stale or unset storage.
  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wp] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sro_readout_rx.sv
// ETROC1 simple-readout receiver: frames header/pixel/trailer words, tags pixel
// words with their ROI index, checks framing and buffers hits in a FWFT FIFO.
module sro_readout_rx
  import sro_rx_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] din,
  input  logic        din_valid,
  input  logic [15:0] roi,
  output logic [29:0] pix_data,
  output logic [3:0]  pix_index,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [11:0] evt_bcid,
  output logic        evt_done,
  output logic        evt_err,
  output logic [15:0] evt_cnt,
  output logic [15:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT + 2);

  logic [29:0]   din_q;
  logic          dv_q;
  logic [15:0]   roi_q;
  state_t        state, state_n;
  logic [15:0]   roi_l, rem, rem_n;
  logic [4:0]    n_l;
  logic [TW-1:0] tmo, tmo_n;
  logic          is_word, is_hdr, is_trl, trl_ok;
  logic          latch, push, done, ferr, drop, pop, full, empty;
  logic [3:0]    nxt_idx;
  hit_t          wr_hit, rd_hit;
  logic [1:0]    err_inc;
  logic [16:0]   err_sum;

  assign is_word = dv_q && (din_q != IDLE_WORD);
  assign is_hdr  = is_word && (din_q[TAG_MSB:TAG_LSB] == HDR_TAG);
  assign is_trl  = is_word && (din_q[TAG_MSB:TAG_LSB] == TRL_TAG);
  assign trl_ok  = is_trl && (din_q[ECHO_MSB:ECHO_LSB] == roi_l)
                   && (din_q[CNT_MSB:CNT_LSB] == {3'b0, n_l});
  // rem holds the ROI bits not yet consumed; its lowest bit is the next pixel.
  assign nxt_idx = lowest_set(rem);

  always_comb begin
    state_n = state;
    rem_n   = rem;
    tmo_n   = tmo;
    latch   = 1'b0;
    push    = 1'b0;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_hdr) latch = 1'b1;
        else if (is_word) ferr = 1'b1;
      end
      ST_DATA, ST_TRAIL: begin
        if (is_hdr) begin
          ferr  = 1'b1;
          latch = 1'b1;
        end else if (is_word) begin
          tmo_n = '0;
          if (state == ST_DATA) begin
            push  = 1'b1;
            rem_n = rem & ~(16'h1 << nxt_idx);
            if (rem_n == '0) state_n = ST_TRAIL;
          end else begin
            done    = trl_ok;
            ferr    = !trl_ok;
            state_n = ST_IDLE;
          end
        end else if (tmo == TW'(TIMEOUT)) begin
          ferr    = 1'b1;
          state_n = ST_IDLE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A header always opens a fresh frame, including a restart mid-frame.
    if (latch) begin
      rem_n   = roi_q;
      tmo_n   = '0;
      state_n = (roi_q == '0) ? ST_TRAIL : ST_DATA;
    end
  end

  assign wr_hit = '{index: nxt_idx, data: din_q};
  assign pop    = pix_valid && pix_ready;
  assign drop   = push && full && !pop;

  sro_rx_fifo #(.W($bits(hit_t)), .AW(FIFO_AW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wr_hit),
    .pop   (pop),
    .rdata (rd_hit),
    .full  (full),
    .empty (empty)
  );

  assign pix_valid = !empty;
  assign pix_data  = rd_hit.data;
  assign pix_index = rd_hit.index;

  assign err_inc = {1'b0, ferr} + {1'b0, drop};
  assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      din_q    <= '0;
      dv_q     <= 1'b0;
      roi_q    <= '0;
      state    <= ST_IDLE;
      rem      <= '0;
      roi_l    <= '0;
      n_l      <= '0;
      tmo      <= '0;
      evt_bcid <= '0;
      evt_done <= 1'b0;
      evt_err  <= 1'b0;
      evt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      din_q    <= din;
      dv_q     <= din_valid;
      roi_q    <= roi;
      state    <= state_n;
      rem      <= rem_n;
      tmo      <= tmo_n;
      evt_done <= done;
      evt_err  <= ferr;
      if (latch) begin
        roi_l    <= roi_q;
        n_l      <= popcnt16(roi_q);
        evt_bcid <= din_q[BCID_MSB:BCID_LSB];
      end
      if (done) evt_cnt <= evt_cnt + 16'd1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule
